// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// Architectural register file plus register-status (rename tag) table.
// Holds REG_NUM x XLEN values and one TAG_W-bit ROB tag per register. A tag of
// zero means "no pending producer"; ROB ids run 1..2**TAG_W-1. x0 is hard-wired
// to zero (tag 0, value 0).
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   defined   - a commit is forwarded to the query ports in the same cycle.
//   undefined - query ports reflect registered state only.
//
// Ports:
//   clk_in                  system clock
//   rst_in                  asynchronous active-low reset
//   rdy_in                  global ready; low freezes all state
//   _clear                  ROB flush: drop every pending tag, ignore launch
//   _rf_launch_ready        launch of an instruction with a destination reg
//   _rf_launch_rob_id       ROB id of the launched instruction
//   _rf_launch_register_id  destination register of the launch
//   _rf_commit_ready        commit of the ROB head with a destination reg
//   _rf_commit_rob_id       ROB id of the committing instruction
//   _rf_commit_register_id  destination register of the commit
//   _rf_commit_value        value retired into the register
//   _ask_rd_1/_ask_rd_2     combinational query addresses
//   _dep_rd_1/_dep_rd_2     pending ROB tag of the queried register (0 = none)
//   _dep_value_1/_dep_value_2  architectural value of the queried register
// -----------------------------------------------------------------------------
module register_file #(
    parameter  int REG_NUM = 32,
    parameter  int XLEN    = 32,
    parameter  int TAG_W   = 5,
    localparam int IDX_W   = $clog2(REG_NUM)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             _clear,
    input  logic             _rf_launch_ready,
    input  logic [TAG_W-1:0] _rf_launch_rob_id,
    input  logic [IDX_W-1:0] _rf_launch_register_id,
    input  logic             _rf_commit_ready,
    input  logic [TAG_W-1:0] _rf_commit_rob_id,
    input  logic [IDX_W-1:0] _rf_commit_register_id,
    input  logic [XLEN-1:0]  _rf_commit_value,
    input  logic [IDX_W-1:0] _ask_rd_1,
    input  logic [IDX_W-1:0] _ask_rd_2,
    output logic [TAG_W-1:0] _dep_rd_1,
    output logic [XLEN-1:0]  _dep_value_1,
    output logic [TAG_W-1:0] _dep_rd_2,
    output logic [XLEN-1:0]  _dep_value_2
);

    logic [XLEN-1:0]  value_q [REG_NUM];
    logic [XLEN-1:0]  value_d [REG_NUM];
    logic [TAG_W-1:0] tag_q   [REG_NUM];
    logic [TAG_W-1:0] tag_d   [REG_NUM];

    logic commit_en;
    logic launch_en;

    // x0 never accepts a write; rdy_in gates every update.
    assign commit_en = rdy_in && _rf_commit_ready && (_rf_commit_register_id != '0);
    assign launch_en = rdy_in && _rf_launch_ready && (_rf_launch_register_id != '0);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every array element gets a default (hold) before any
        // conditional write, so no path leaves a bit unassigned and no latch
        // is inferred.
        value_d = value_q;
        tag_d   = tag_q;

        if (commit_en) begin
            value_d[_rf_commit_register_id] = _rf_commit_value;
            // Only clear the tag if this commit is still the newest producer;
            // otherwise a younger launch owns the register.
            if (tag_q[_rf_commit_register_id] == _rf_commit_rob_id) begin
                tag_d[_rf_commit_register_id] = '0;
            end
        end

        // Applied after the commit so that a same-register launch wins the tag.
        if (rdy_in && _clear) begin
            for (int i = 0; i < REG_NUM; i++) begin
                tag_d[i] = '0;
            end
        end else if (launch_en) begin
            tag_d[_rf_launch_register_id] = _rf_launch_rob_id;
        end

        value_d[0] = '0;
        tag_d[0]   = '0;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: the whole array is reset because a reset must expose zero values
    // and zero tags on the query ports; this forces flops rather than a RAM
    // macro, which is acceptable at 32 entries. Sequential state uses <= only;
    // the combinational block above uses blocking = so later lines see
    // earlier updates within the same evaluation.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            value_q <= '{default: '0};
            tag_q   <= '{default: '0};
        end else begin
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end

    // -------------------------------------------------------------------------
    // Combinational query ports
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] ask   [2];
    logic [TAG_W-1:0] q_tag [2];
    logic [XLEN-1:0]  q_val [2];

    assign ask[0] = _ask_rd_1;
    assign ask[1] = _ask_rd_2;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            q_tag[k] = tag_q[ask[k]];
            q_val[k] = value_q[ask[k]];
`ifdef REGFILE_BYPASS_EN
            // Forward a same-cycle commit; commit_en already excludes x0.
            if (commit_en && (ask[k] == _rf_commit_register_id)) begin
                q_val[k] = _rf_commit_value;
                if (tag_q[ask[k]] == _rf_commit_rob_id) begin
                    q_tag[k] = '0;
                end
            end
`else
            // Commits become visible through the registers on the next cycle.
`endif
            if (ask[k] == '0) begin
                q_tag[k] = '0;
                q_val[k] = '0;
            end
        end
    end

    assign _dep_rd_1    = q_tag[0];
    assign _dep_value_1 = q_val[0];
    assign _dep_rd_2    = q_tag[1];
    assign _dep_value_2 = q_val[1];

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//
// Self-checking bench for register_file: directed scenarios followed by a
// randomized phase, all compared against a behavioural model of the register
// file kept as plain arrays. Build with REGFILE_BYPASS_EN defined or not; the
// model follows the same macro.
// -----------------------------------------------------------------------------
module tb_register_file;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        l_ready;
    logic [4:0]  l_rob;
    logic [4:0]  l_rd;
    logic        c_ready;
    logic [4:0]  c_rob;
    logic [4:0]  c_rd;
    logic [31:0] c_val;
    logic [4:0]  ask_1;
    logic [4:0]  ask_2;
    logic [4:0]  dep_rd_1;
    logic [31:0] dep_value_1;
    logic [4:0]  dep_rd_2;
    logic [31:0] dep_value_2;

    int total = 0;
    int bad   = 0;

    // Reference model: architectural contents as plain arrays.
    logic [31:0] ref_val [32];
    logic [4:0]  ref_tag [32];

    always #5 clk_in = ~clk_in;

    register_file dut (
        .clk_in                 (clk_in),
        .rst_in                 (rst_in),
        .rdy_in                 (rdy_in),
        ._clear                 (clear),
        ._rf_launch_ready       (l_ready),
        ._rf_launch_rob_id      (l_rob),
        ._rf_launch_register_id (l_rd),
        ._rf_commit_ready       (c_ready),
        ._rf_commit_rob_id      (c_rob),
        ._rf_commit_register_id (c_rd),
        ._rf_commit_value       (c_val),
        ._ask_rd_1              (ask_1),
        ._ask_rd_2              (ask_2),
        ._dep_rd_1              (dep_rd_1),
        ._dep_value_1           (dep_value_1),
        ._dep_rd_2              (dep_rd_2),
        ._dep_value_2           (dep_value_2)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            ref_val[i] = '0;
            ref_tag[i] = '0;
        end
    endfunction

    // Expected query answers, written from the behavioural rules.
    function automatic logic [31:0] exp_val(input logic [4:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (rdy_in && c_ready && c_rd == a) return c_val;
`endif
        return ref_val[a];
    endfunction

    function automatic logic [31:0] exp_tag(input logic [4:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (rdy_in && c_ready && c_rd == a)
            return (ref_tag[a] == c_rob) ? 32'd0 : 32'(ref_tag[a]);
`endif
        return 32'(ref_tag[a]);
    endfunction

    // Apply one clock of architectural effects using the inputs sampled at the edge.
    function automatic void model_clock();
        logic [4:0] old_tag [32];
        if (!rdy_in) return;
        old_tag = ref_tag;
        if (c_ready && c_rd != 0) begin
            ref_val[c_rd] = c_val;
            if (old_tag[c_rd] == c_rob) ref_tag[c_rd] = 0;
        end
        if (clear) begin
            for (int i = 0; i < 32; i++) ref_tag[i] = 0;
        end else if (l_ready && l_rd != 0) begin
            ref_tag[l_rd] = l_rob;
        end
    endfunction

    task automatic idle();
        rdy_in  = 1'b1;
        clear   = 1'b0;
        l_ready = 1'b0;
        l_rob   = '0;
        l_rd    = '0;
        c_ready = 1'b0;
        c_rob   = '0;
        c_rd    = '0;
        c_val   = '0;
    endtask

    task automatic set_in(input logic lv, input logic [4:0] lrob, input logic [4:0] lrd,
                          input logic cv, input logic [4:0] crob, input logic [4:0] crd,
                          input logic [31:0] cval, input logic clr, input logic rdy);
        l_ready = lv;
        l_rob   = lrob;
        l_rd    = lrd;
        c_ready = cv;
        c_rob   = crob;
        c_rd    = crd;
        c_val   = cval;
        clear   = clr;
        rdy_in  = rdy;
    endtask

    task automatic look(input logic [4:0] a1, input logic [4:0] a2);
        ask_1 = a1;
        ask_2 = a2;
        #1;
    endtask

    // Check both query ports against the model, clock once, advance the model.
    task automatic step();
        #1;
        check("dep_rd_1",    32'(dep_rd_1),  exp_tag(ask_1));
        check("dep_value_1", dep_value_1,    exp_val(ask_1));
        check("dep_rd_2",    32'(dep_rd_2),  exp_tag(ask_2));
        check("dep_value_2", dep_value_2,    exp_val(ask_2));
        @(posedge clk_in);
        model_clock();
        #1;
        idle();
    endtask

    initial begin
        rst_in = 1'b0;
        idle();
        ask_1 = '0;
        ask_2 = '0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;

        // Reset state.
        look(5, 31);
        check("rst_x5_tag",   32'(dep_rd_1), 32'd0);
        check("rst_x5_val",   dep_value_1,   32'd0);
        check("rst_x31_tag",  32'(dep_rd_2), 32'd0);
        check("rst_x31_val",  dep_value_2,   32'd0);
        rst_in = 1'b1;

        // Launch then commit.
        set_in(1, 3, 5, 0, 0, 0, 0, 0, 1); step();
        look(5, 5);
        check("launch_x5_tag", 32'(dep_rd_1), 32'd3);
        set_in(0, 0, 0, 1, 3, 5, 32'hDEADBEEF, 0, 1); step();
        look(5, 0);
        check("commit_x5_tag", 32'(dep_rd_1), 32'd0);
        check("commit_x5_val", dep_value_1,   32'hDEADBEEF);

        // Older commit must not clear a younger producer's tag.
        set_in(1, 4, 7, 0, 0, 0, 0, 0, 1); step();
        set_in(1, 9, 7, 0, 0, 0, 0, 0, 1); step();
        set_in(0, 0, 0, 1, 4, 7, 32'h11, 0, 1); step();
        look(7, 7);
        check("old_commit_val", dep_value_1,   32'h11);
        check("old_commit_tag", 32'(dep_rd_2), 32'd9);
        set_in(1, 12, 7, 1, 9, 7, 32'h22, 0, 1); step();
        look(7, 7);
        check("same_rd_val", dep_value_1,   32'h22);
        check("same_rd_tag", 32'(dep_rd_1), 32'd12);

        // x0 stays zero.
        set_in(1, 6, 0, 1, 6, 0, 32'hFFFFFFFF, 0, 1); step();
        look(0, 0);
        check("x0_tag", 32'(dep_rd_1), 32'd0);
        check("x0_val", dep_value_2,   32'd0);

        // Clear drops tags and the same-cycle launch, keeps values.
        set_in(1, 2, 1, 0, 0, 0, 0, 0, 1); step();
        set_in(1, 5, 2, 1, 30, 1, 32'hA5A5, 0, 1); step();
        look(1, 2);
        check("pre_clear_x1_tag", 32'(dep_rd_1), 32'd2);
        check("pre_clear_x2_tag", 32'(dep_rd_2), 32'd5);
        set_in(1, 7, 3, 0, 0, 0, 0, 1, 1); step();
        look(1, 3);
        check("clear_x1_tag", 32'(dep_rd_1),  32'd0);
        check("clear_x1_val", dep_value_1,    32'hA5A5);
        check("clear_x3_tag", 32'(dep_rd_2),  32'd0);
        look(2, 5);
        check("clear_x2_tag", 32'(dep_rd_1),  32'd0);
        check("clear_x5_val", dep_value_2,    32'hDEADBEEF);

        // rdy_in low freezes state.
        set_in(1, 8, 3, 1, 8, 3, 32'h77, 0, 0); step();
        look(3, 3);
        check("stall_x3_tag", 32'(dep_rd_1), 32'd0);
        check("stall_x3_val", dep_value_2,   32'd0);

        // Asynchronous reset in the middle of a cycle.
        set_in(1, 10, 9, 0, 0, 0, 0, 0, 1); step();
        rst_in = 1'b0;
        model_reset();
        look(9, 5);
        check("midrst_x9_tag", 32'(dep_rd_1), 32'd0);
        check("midrst_x5_val", dep_value_2,   32'd0);
        #2;
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;

        // Commit-to-query forwarding (or its absence).
        set_in(1, 10, 8, 0, 0, 0, 0, 0, 1); step();
        set_in(0, 0, 0, 1, 10, 8, 32'h1234, 0, 1);
        look(8, 8);
`ifdef REGFILE_BYPASS_EN
        check("bypass_tag", 32'(dep_rd_1), 32'd0);
        check("bypass_val", dep_value_2,   32'h1234);
`else
        check("nobypass_tag", 32'(dep_rd_1), 32'd10);
        check("nobypass_val", dep_value_2,   32'd0);
`endif
        step();
        look(8, 8);
        check("after_commit_tag", 32'(dep_rd_1), 32'd0);
        check("after_commit_val", dep_value_2,   32'h1234);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] crd;
            crd = 5'($urandom_range(0, 31));
            set_in(1'($urandom_range(0, 3) != 0), 5'($urandom_range(1, 31)), 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)),
                   ($urandom_range(0, 1) != 0) ? ref_tag[crd] : 5'($urandom_range(1, 31)),
                   crd, $urandom(),
                   1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) != 0));
            ask_1 = ($urandom_range(0, 2) == 0) ? crd : 5'($urandom_range(0, 31));
            ask_2 = ($urandom_range(0, 3) == 0) ? ask_1 : 5'($urandom_range(0, 31));
            step();
        end

        // Final sweep of every register after the random phase.
        for (int r = 0; r < 32; r++) begin
            look(5'(r), 5'(r));
            check("sweep_tag", 32'(dep_rd_1), 32'(ref_tag[r]));
            check("sweep_val", dep_value_2,   ref_val[r]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
